tff_down_counter: RTL and testbench

//  Loadable, synchronous down-counter built from toggle flip-flops; the counting-down

---
 rtl/tff_down_counter_pkg.sv | 14 +
 rtl/tff_down_counter_t_ff.sv | 23 ++
 rtl/tff_down_counter.sv | 134 +++++++++++++
 tb/tb_tff_down_counter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tff_down_counter_pkg.sv
// Shared definitions for the toggle-flip-flop down-counter.
//   state_t : controller state encoding
//             IDLE  - count is zero, nothing in progress
//             RUN   - counting, enable was high on the last edge
//             PAUSE - count held, enable was low on the last edge
package tff_down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

endpackage : tff_down_counter_pkg

// File: rtl/tff_down_counter_t_ff.sv
// Single toggle flip-flop, the building block of the count register.
// State changes on the falling edge of clk.
// Ports:
//   q     : stored bit
//   t     : toggle request, q inverts on the edge when high
//   clk   : clock
//   reset : synchronous, active-low, forces q to 0
module t_ff_sync (
    output logic q,
    input  logic t,
    input  logic clk,
    input  logic reset
);

    always_ff @(negedge clk) begin
        if (!reset) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule : t_ff_sync

// File: rtl/tff_down_counter.sv
// Loadable down-counter built from toggle flip-flops, used as an interval /
// timeout timer. A nonzero load starts a count; each enabled edge decrements
// it; reaching terminal count (1 -> 0) pulses done for one cycle. With the
// auto-reload mode active the count restarts from the last loaded value
// instead of stopping, which makes the block a periodic tick generator.
// All state changes on the falling edge of clk.
// Parameters:
//   W      : counter width in bits (>= 2)
//   RELOAD : auto-reload mode after reset
// Ports:
//   clk         : clock
//   reset       : synchronous, active-low
//   load        : capture load_val into the count and the reload register
//   load_val    : start / period value
//   en          : decrement enable
//   auto_reload : reload at terminal count instead of stopping
//   q           : current count
//   busy        : a count is in progress (RUN or PAUSE)
//   done        : one-cycle pulse after terminal count
module tff_down_counter
    import tff_down_counter_pkg::*;
#(
    parameter int W      = 4,
    parameter bit RELOAD = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         auto_reload,
    output logic [W-1:0] q,
    output logic         busy,
    output logic         done
);

    localparam logic [W-1:0] COUNT_ONE = W'(1);

    state_t         state_reg;
    state_t         state_next;
    logic [W-1:0]   reload_reg;
    logic           done_reg;
    logic           done_next;
    logic           mode_reg;

    logic [W-1:0]   count;
    logic [W-1:0]   toggle;
    logic           active;
    logic           at_one;
    logic           at_zero;
    logic           term;
    logic           reload_hit;
    logic           dec;

    assign active  = (state_reg != IDLE);
    assign at_one  = (count == COUNT_ONE);
    assign at_zero = (count == '0);

    // Terminal count only counts when no load competes for the same edge;
    // a load always wins and suppresses the done pulse.
    assign term       = !load && active && en && at_one;
    assign reload_hit = term && mode_reg;
    // Plain decrement, including the final 1 -> 0 step when not reloading.
    // at_zero is redundant while active but keeps the count from ever
    // wrapping below zero.
    assign dec        = !load && active && en && !at_zero && !reload_hit;

    // Count register: each bit is a T flip-flop. Loads and reloads toggle
    // exactly the bits that differ from the target value; a decrement
    // toggles bit i when every lower bit is zero (borrow ripple).
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            logic dec_toggle;

            if (gi == 0) begin : g_lsb
                assign dec_toggle = dec;
            end else begin : g_upper
                assign dec_toggle = dec && (count[gi-1:0] == '0);
            end

            assign toggle[gi] = load       ? (count[gi] ^ load_val[gi])   :
                                reload_hit ? (count[gi] ^ reload_reg[gi]) :
                                             dec_toggle;

            t_ff_sync u_t_ff (
                .q     (count[gi]),
                .t     (toggle[gi]),
                .clk   (clk),
                .reset (reset)
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        done_next  = term;

        if (load) begin
            if (load_val != '0) begin
                state_next = en ? RUN : PAUSE;
            end else begin
                state_next = IDLE;
            end
        end else if (active) begin
            if (en) begin
                state_next = (at_one && !mode_reg) ? IDLE : RUN;
            end else begin
                state_next = PAUSE;
            end
        end
    end

    always_ff @(negedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            reload_reg <= '0;
            done_reg   <= 1'b0;
            mode_reg   <= RELOAD;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            // Mode follows the input each edge; RELOAD only seeds it at reset.
            mode_reg  <= auto_reload;
            if (load) begin
                reload_reg <= load_val;
            end
        end
    end

    assign q    = count;
    assign busy = active;
    assign done = done_reg;

endmodule : tff_down_counter

// File: tb/tb_tff_down_counter.sv
module tb_tff_down_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic         auto_reload;
    logic [W-1:0] q;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tff_down_counter #(
        .W      (W),
        .RELOAD (1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .q           (q),
        .busy        (busy),
        .done        (done)
    );

    // Inputs change right after a rising edge; the DUT acts on the following
    // falling edge; outputs are observed at the next rising edge.
    task automatic tick();
        @(posedge clk);
        $display("t=%0t reset=%b load=%b val=%0d en=%b ar=%b -> q=%0d busy=%b done=%b",
                 $time, reset, load, load_val, en, auto_reload, q, busy, done);
    endtask

    task automatic test_reset();
        reset = 1'b0; load = 1'b1; load_val = 4'd7; en = 1'b1; auto_reload = 1'b0;
        repeat (2) begin
            tick();
            checks++;
            if ({q, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold: q=%0d busy=%b done=%b expected q=0 busy=0 done=0", q, busy, done);
            end
        end
    endtask

    task automatic test_count();
        reset = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1;
        tick();
        checks++;
        if ({q, busy, done} !== {4'd5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL count_load: q=%0d busy=%b done=%b expected q=5 busy=1 done=0", q, busy, done);
        end
        load = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if ({q, busy, done} !== {W'(5 - i), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL count_dec: q=%0d busy=%b done=%b expected q=%0d busy=1 done=0", q, busy, done, 5 - i);
            end
        end
        tick();
        checks++;
        if ({q, busy, done} !== {4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL count_terminal: q=%0d busy=%b done=%b expected q=0 busy=0 done=1", q, busy, done);
        end
        // IDLE with en high: stays at zero, no wrap, done already gone.
        tick();
        checks++;
        if ({q, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL count_no_wrap: q=%0d busy=%b done=%b expected q=0 busy=0 done=0", q, busy, done);
        end
    endtask

    task automatic test_pause();
        logic       en_seq  [4];
        logic [3:0] q_seq   [4];
        en_seq[0] = 1'b1; en_seq[1] = 1'b0; en_seq[2] = 1'b0; en_seq[3] = 1'b1;
        q_seq[0]  = 4'd5; q_seq[1]  = 4'd5; q_seq[2]  = 4'd5; q_seq[3]  = 4'd4;
        load = 1'b1; load_val = 4'd6; en = 1'b1;
        tick();
        checks++;
        if ({q, busy, done} !== {4'd6, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL pause_load: q=%0d busy=%b done=%b expected q=6 busy=1 done=0", q, busy, done);
        end
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en = en_seq[i];
            tick();
            checks++;
            if ({q, busy, done} !== {q_seq[i], 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL pause_step%0d: q=%0d busy=%b done=%b expected q=%0d busy=1 done=0",
                         i, q, busy, done, q_seq[i]);
            end
        end
        load = 1'b1; load_val = 4'd0;
        tick();
        checks++;
        if ({q, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL pause_clear: q=%0d busy=%b done=%b expected q=0 busy=0 done=0", q, busy, done);
        end
        load = 1'b0;
    endtask

    task automatic test_auto_reload();
        auto_reload = 1'b1; load = 1'b1; load_val = 4'd3; en = 1'b1;
        tick();
        checks++;
        if ({q, busy, done} !== {4'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reload_load: q=%0d busy=%b done=%b expected q=3 busy=1 done=0", q, busy, done);
        end
        load = 1'b0;
        repeat (2) begin
            tick();
            checks++;
            if ({q, busy, done} !== {4'd2, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reload_q2: q=%0d busy=%b done=%b expected q=2 busy=1 done=0", q, busy, done);
            end
            tick();
            checks++;
            if ({q, busy, done} !== {4'd1, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reload_q1: q=%0d busy=%b done=%b expected q=1 busy=1 done=0", q, busy, done);
            end
            tick();
            checks++;
            if ({q, busy, done} !== {4'd3, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL reload_wrap: q=%0d busy=%b done=%b expected q=3 busy=1 done=1", q, busy, done);
            end
        end
        // Period of one: done on every enabled edge, count parked at 1.
        load = 1'b1; load_val = 4'd1;
        tick();
        checks++;
        if ({q, busy, done} !== {4'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reload1_load: q=%0d busy=%b done=%b expected q=1 busy=1 done=0", q, busy, done);
        end
        load = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if ({q, busy, done} !== {4'd1, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL reload1_tick: q=%0d busy=%b done=%b expected q=1 busy=1 done=1", q, busy, done);
            end
        end
        auto_reload = 1'b0; load = 1'b1; load_val = 4'd0;
        tick();
        checks++;
        if ({q, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reload_clear: q=%0d busy=%b done=%b expected q=0 busy=0 done=0", q, busy, done);
        end
        load = 1'b0;
    endtask

    task automatic test_load_override();
        load = 1'b1; load_val = 4'd4; en = 1'b1;
        tick();
        checks++;
        if ({q, busy, done} !== {4'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL override_load: q=%0d busy=%b done=%b expected q=4 busy=1 done=0", q, busy, done);
        end
        load = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({q, busy, done} !== {W'(4 - i), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL override_dec: q=%0d busy=%b done=%b expected q=%0d busy=1 done=0", q, busy, done, 4 - i);
            end
        end
        // Count is 1 here: load and terminal count share the edge, load wins.
        load = 1'b1; load_val = 4'd9;
        tick();
        checks++;
        if ({q, busy, done} !== {4'd9, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL override_reload9: q=%0d busy=%b done=%b expected q=9 busy=1 done=0", q, busy, done);
        end
        load_val = 4'd0;
        tick();
        checks++;
        if ({q, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL override_load0: q=%0d busy=%b done=%b expected q=0 busy=0 done=0", q, busy, done);
        end
        load = 1'b0;
        tick();
        checks++;
        if ({q, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL override_idle: q=%0d busy=%b done=%b expected q=0 busy=0 done=0", q, busy, done);
        end
    endtask

    task automatic test_reset_mid();
        load = 1'b1; load_val = 4'd15; en = 1'b1;
        tick();
        checks++;
        if ({q, busy, done} !== {4'd15, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL abort_load: q=%0d busy=%b done=%b expected q=15 busy=1 done=0", q, busy, done);
        end
        load = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if ({q, busy, done} !== {W'(15 - i), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL abort_dec: q=%0d busy=%b done=%b expected q=%0d busy=1 done=0", q, busy, done, 15 - i);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({q, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_reset: q=%0d busy=%b done=%b expected q=0 busy=0 done=0", q, busy, done);
        end
        reset = 1'b1;
        repeat (2) begin
            tick();
            checks++;
            if ({q, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL abort_after: q=%0d busy=%b done=%b expected q=0 busy=0 done=0", q, busy, done);
            end
        end
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
        @(posedge clk);
        test_reset();
        test_count();
        test_pause();
        test_auto_reload();
        test_load_override();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_tff_down_counter
